// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR keystream sequencer.
package lfsr_pkg;
    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_SAFE_SEED = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARMUP,
        RUN,
        DRAIN
    } ctrl_state_t;
endpackage

// File: rtl/lfsr_stream_ctrl.sv
// Sequencer for an 8-bit LFSR keystream: seeding, warm-up stepping, byte XOR, message framing.
// Optional macro KS_STUCK_DETECT_EN adds a sticky ks_stuck flag that stalls input while set.
module lfsr_stream_ctrl
    import lfsr_pkg::*;
#(
    parameter int WARMUP_CYCLES = 4,
    parameter int LEN_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [LFSR_W-1:0] out_data,
    input  logic              out_ready,
    output logic [LFSR_W-1:0] lfsr_seed,
    output logic              lfsr_load,
    output logic              lfsr_enable,
    input  logic [LFSR_W-1:0] keystream,
    output logic              busy,
`ifdef KS_STUCK_DETECT_EN
    output logic              ks_stuck,
`endif
    output logic              done
);
    localparam int WU_W = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES);
    localparam logic [WU_W-1:0] WU_LAST = WU_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next;
    logic [LFSR_W-1:0] r_seed;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [WU_W-1:0]   r_wu_cnt;
    logic              r_out_vld;
    logic [LFSR_W-1:0] r_out_dat;
    logic              r_done;
    logic              w_accept;
    logic              w_run_rdy;
    logic              w_last;

`ifdef KS_STUCK_DETECT_EN
    logic              r_stuck;
    logic              r_en_d;
    logic [LFSR_W-1:0] r_ks_prev;

    // Compare the keystream the cycle after each advance against its pre-advance value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stuck   <= 1'b0;
            r_en_d    <= 1'b0;
            r_ks_prev <= '0;
        end else begin
            r_en_d <= lfsr_enable;
            if (lfsr_enable)
                r_ks_prev <= keystream;
            if (cfg_start)
                r_stuck <= 1'b0;
            else if (r_en_d && (keystream == r_ks_prev || keystream == '0))
                r_stuck <= 1'b1;
        end
    end

    assign ks_stuck  = r_stuck;
    assign w_run_rdy = (!r_out_vld || out_ready) && !r_stuck;
`else
    assign w_run_rdy = !r_out_vld || out_ready;
`endif

    // Counter never exceeds len-1, so len = 2^LEN_W-1 completes without wrap.
    assign w_last = (LEN_W'(r_cnt + 1'b1) == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_enable = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start)
                    w_next = LOAD;
            end
            LOAD: begin
                lfsr_load = 1'b1;
                if (r_len == '0)
                    w_next = DRAIN;
                else if (WARMUP_CYCLES > 0)
                    w_next = WARMUP;
                else
                    w_next = RUN;
            end
            WARMUP: begin
                lfsr_enable = 1'b1;
                if (r_wu_cnt == WU_LAST)
                    w_next = RUN;
            end
            RUN: begin
                in_ready    = w_run_rdy;
                w_accept    = in_valid && w_run_rdy;
                lfsr_enable = w_accept;
                if (w_accept && w_last)
                    w_next = DRAIN;
            end
            DRAIN: begin
                if (!r_out_vld || out_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seed    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_wu_cnt  <= '0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_seed   <= (cfg_seed == '0) ? LFSR_SAFE_SEED : cfg_seed;
                        r_len    <= cfg_len;
                        r_cnt    <= '0;
                        r_wu_cnt <= '0;
                    end
                end
                WARMUP: r_wu_cnt <= r_wu_cnt + 1'b1;
                RUN: begin
                    if (w_accept) begin
                        r_out_vld <= 1'b1;
                        r_out_dat <= in_data ^ keystream;
                        r_cnt     <= r_cnt + 1'b1;
                    end else if (out_ready) begin
                        r_out_vld <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!r_out_vld || out_ready) begin
                        r_out_vld <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign lfsr_seed = r_seed;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// Bench for lfsr_stream_ctrl: one instance without warm-up (LEN_W=16), one with 4 warm-up
// steps and LEN_W=4 for the full-length boundary; each drives its own LFSR stand-in.
module tb_lfsr_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, start4;
    logic [7:0]  cfg_seed;
    logic [15:0] cfg_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic       in_ready, out_valid, lfsr_load, lfsr_enable, busy, done;
    logic [7:0] out_data, lfsr_seed;
    logic       in_ready4, out_valid4, lfsr_load4, lfsr_enable4, busy4, done4;
    logic [7:0] out_data4, lfsr_seed4;
    logic [7:0] ks0 = 8'h00, ks4 = 8'h00;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    lfsr_stream_ctrl #(.WARMUP_CYCLES(0), .LEN_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_seed(cfg_seed), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .lfsr_seed(lfsr_seed), .lfsr_load(lfsr_load), .lfsr_enable(lfsr_enable),
        .keystream(ks0), .busy(busy), .done(done)
    );

    lfsr_stream_ctrl #(.WARMUP_CYCLES(4), .LEN_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .cfg_start(start4), .cfg_seed(cfg_seed), .cfg_len(cfg_len[3:0]),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
        .lfsr_seed(lfsr_seed4), .lfsr_load(lfsr_load4), .lfsr_enable(lfsr_enable4),
        .keystream(ks4), .busy(busy4), .done(done4)
    );

    // x^8+x^6+x^5+x^4+1, shift-left form: 8'hA5 -> 8'h4A.
    function automatic logic [7:0] step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk) begin
        if (lfsr_load) ks0 <= lfsr_seed;
        else if (lfsr_enable) ks0 <= step(ks0);
        if (lfsr_load4) ks4 <= lfsr_seed4;
        else if (lfsr_enable4) ks4 <= step(ks4);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected ciphertext: keystream starts at the (safe) seed, skips the warm-up, steps per byte.
    task automatic build_exp(input logic [7:0] seed, input int warm);
        logic [7:0] ks;
        ks = (seed == 8'h00) ? 8'h01 : seed;
        exp_q.delete();
        repeat (warm) ks = step(ks);
        foreach (tx_q[i]) begin
            exp_q.push_back(tx_q[i] ^ ks);
            ks = step(ks);
        end
    endtask

    task automatic start_msg(input logic [7:0] seed, input int len);
        @(negedge clk);
        cfg_seed  = seed;
        cfg_len   = 16'(len);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        chk("load_pulse", lfsr_load, 1);
        chk("load_seed", lfsr_seed, (seed == 8'h00) ? 8'h01 : seed);
    endtask

    task automatic run_msg(input int len, input int vld_pct, input int rdy_pct);
        int sent, got, last_hs, done_cyc;
        logic prev_stall;
        logic [7:0] prev_d;
        sent = 0; got = 0; last_hs = -1; done_cyc = -1; prev_stall = 1'b0; prev_d = 8'h00;
        for (int cyc = 0; cyc < 500 && done_cyc < 0; cyc++) begin
            in_valid  = (sent < len) && ($urandom_range(0, 99) < vld_pct);
            in_data   = (sent < len) ? tx_q[sent] : 8'($urandom);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (done) done_cyc = cyc;
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
            end
            chk("enable_tied_to_accept", lfsr_enable, in_valid && in_ready);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (got < exp_q.size()) chk("cipher", out_data, exp_q[got]);
                else chk("extra_output", got + 1, exp_q.size());
                got++;
                last_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("done_seen", done_cyc >= 0, 1);
        chk("out_count", got, exp_q.size());
        if (len > 0) chk("done_latency", done_cyc - last_hs, 1);
        #1;
        chk("done_one_cycle", done, 0);
    endtask

    typedef struct packed {
        logic [7:0]  seed;
        logic [7:0]  len;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    vec_t tbl [5];

    int         len_r, sent4, got4, en_cnt, dseen;
    logic [7:0] seed_r;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hA5, 8'd2, 32'h0000_0000, 32'h0000_4AA5};
        tbl[1] = '{8'h00, 8'd1, 32'h0000_00FF, 32'h0000_00FE};
        tbl[2] = '{8'h01, 8'd3, 32'h0000_0000, 32'h0004_0201};
        tbl[3] = '{8'h80, 8'd2, 32'h0000_F00F, 32'h0000_F18F};
        tbl[4] = '{8'hFF, 8'd2, 32'h0000_0000, 32'h0000_FEFF};

        rst = 1'b1; cfg_start = 1'b0; start4 = 1'b0; cfg_seed = 8'h00; cfg_len = 16'h0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_load", lfsr_load, 0);
        chk("rst_enable", lfsr_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_seed", lfsr_seed, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            tx_q.delete();
            exp_q.delete();
            for (int i = 0; i < int'(tbl[v].len); i++) begin
                tx_q.push_back(tbl[v].d[8*i +: 8]);
                exp_q.push_back(tbl[v].e[8*i +: 8]);
            end
            start_msg(tbl[v].seed, int'(tbl[v].len));
            run_msg(int'(tbl[v].len), 100, 100);
        end

        // Warm-up of 4 and a full-length message (LEN_W=4, len=15) on the second instance.
        tx_q.delete();
        for (int i = 0; i < 15; i++) tx_q.push_back(8'($urandom));
        build_exp(8'h5A, 4);
        @(negedge clk);
        cfg_seed = 8'h5A; cfg_len = 16'd15; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        sent4 = 0; got4 = 0; en_cnt = 0; dseen = 0;
        for (int c = 0; c < 80 && dseen == 0; c++) begin
            in_valid  = (sent4 < 15);
            in_data   = (sent4 < 15) ? tx_q[sent4] : 8'h00;
            out_ready = 1'b1;
            #1;
            if (done4) dseen = 1;
            if (in_ready4 && sent4 == 0) begin
                chk("warmup_enable_count", en_cnt, 4);
                chk("warmup_no_early_out", out_valid4, 0);
            end
            if (!in_ready4 && lfsr_enable4) en_cnt++;
            if (in_valid && in_ready4) sent4++;
            if (out_valid4 && out_ready) begin
                if (got4 < exp_q.size()) chk("warmup_cipher", out_data4, exp_q[got4]);
                got4++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("full_len_done", dseen, 1);
        chk("full_len_count", got4, 15);
        chk("full_len_idle", busy4, 0);

        // Backpressure: three stalled cycles with a byte waiting.
        tx_q = '{8'h11, 8'h22, 8'h33};
        build_exp(8'h3C, 0);
        start_msg(8'h3C, 3);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        #1 chk("bp_first_ready", in_ready, 1);
        @(negedge clk);
        in_data = 8'h22; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_no_enable", lfsr_enable, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data_stable", out_data, exp_q[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_out0", out_data, exp_q[0]);
        chk("bp_resume_ready", in_ready, 1);
        @(negedge clk);
        in_data = 8'h33;
        #1 chk("bp_out1", out_data, exp_q[1]);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("bp_out2", out_data, exp_q[2]);
        chk("bp_drain_ready", in_ready, 0);
        @(negedge clk);
        #1 chk("bp_done", done, 1);
        out_ready = 1'b0;

        // Empty message.
        start_msg(8'h77, 0);
        @(negedge clk);
        #1 chk("len0_no_valid", out_valid, 0);
        chk("len0_load_once", lfsr_load, 0);
        chk("len0_busy", busy, 1);
        @(negedge clk);
        #1 chk("len0_done", done, 1);
        chk("len0_idle", busy, 0);
        @(negedge clk);
        #1 chk("len0_done_one_cycle", done, 0);

        // cfg_start while running must not replace seed or length.
        tx_q = '{8'h00, 8'h00};
        exp_q = '{8'hA5, 8'h4A};
        start_msg(8'hA5, 2);
        @(negedge clk);
        cfg_seed = 8'h00; cfg_len = 16'd7; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1 chk("ignore_no_load", lfsr_load, 0);
        chk("ignore_seed", lfsr_seed, 8'hA5);
        run_msg(2, 100, 100);

        // Asynchronous reset after one of three bytes, then a clean rerun.
        start_msg(8'hA5, 3);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        #1 chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_enable", lfsr_enable, 0);
        chk("arst_busy", busy, 0);
        chk("arst_out_data", out_data, 8'h00);
        chk("arst_seed", lfsr_seed, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("arst_no_done", done, 0);
        tx_q = '{8'h00, 8'h00};
        exp_q = '{8'hA5, 8'h4A};
        start_msg(8'hA5, 2);
        run_msg(2, 100, 100);

        // Randomized messages against the model.
        for (int m = 0; m < 25; m++) begin
            len_r  = $urandom_range(0, 6);
            seed_r = (m == 0) ? 8'h00 : 8'($urandom);
            tx_q.delete();
            for (int i = 0; i < len_r; i++) tx_q.push_back(8'($urandom));
            build_exp(seed_r, 0);
            start_msg(seed_r, len_r);
            run_msg(len_r, $urandom_range(40, 100), $urandom_range(30, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_stream_ctrl.md
Name: lfsr_stream_ctrl

Overview:
- Sequencer for the 8-bit LFSR keystream generator. Drives its `seed`, `load_seed` and `enable` inputs and consumes its `keystream` output.
- Sits between a byte-wide plaintext source and ciphertext sink. Each accepted byte is XORed with the current keystream byte, and the LFSR advances exactly once per byte.
- Handles per-message seeding, warm-up stepping, message length counting and an end-of-message done pulse.

Parameters:
- WARMUP_CYCLES, 4, LFSR advances discarded after seed load and before the first data byte (0 allowed).
- LEN_W, 16, width of the message length field.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cfg_start  input  1  single-cycle pulse; begin a message (ignored unless IDLE)
- cfg_seed  input  8  seed for the message, sampled on cfg_start
- cfg_len  input  LEN_W  bytes in the message, sampled on cfg_start; 0 means an empty message
- in_valid  input  1  plaintext byte valid
- in_data  input  8  plaintext byte
- in_ready  output  1  controller accepts in_data this cycle
- out_valid  output  1  ciphertext byte valid
- out_data  output  8  ciphertext byte
- out_ready  input  1  sink accepts out_data
- lfsr_seed  output  8  to LFSR seed
- lfsr_load  output  1  to LFSR load_seed
- lfsr_enable  output  1  to LFSR enable
- keystream  input  8  from LFSR; holds the updated value the cycle after a load or enable edge
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when the last ciphertext byte is taken by the sink

Behaviour:
- Reset values: state IDLE; in_ready, out_valid, lfsr_load, lfsr_enable, busy and done all 0; out_data and lfsr_seed 8'h00; counters 0.
- States: IDLE, LOAD, WARMUP, RUN, DRAIN.
- IDLE:
  - On cfg_start, register the seed: cfg_seed, or 8'h01 if cfg_seed == 0.
  - Register len = cfg_len, then go to LOAD.
- LOAD:
  - lfsr_load = 1 for exactly one cycle; lfsr_seed holds the registered seed.
  - Next state is WARMUP if WARMUP_CYCLES > 0, else RUN.
  - If len == 0, go directly to DRAIN instead of WARMUP or RUN.
- WARMUP:
  - lfsr_enable = 1 for exactly WARMUP_CYCLES consecutive cycles, then RUN.
- RUN:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready. On accept:
    - out_data <= in_data ^ keystream (keystream as sampled in the accept cycle);
    - out_valid <= 1;
    - lfsr_enable = 1 in that same cycle;
    - byte count increments.
  - Sustains one byte per cycle with continuous valid/ready.
  - lfsr_enable is combinationally tied to the accept event; it is never asserted without an accept.
  - After the accept of byte number len, go to DRAIN. in_ready is 0 from the next cycle.
- DRAIN:
  - Hold out_valid until out_ready is seen.
  - On the handshake: out_valid <= 0, done pulses 1 cycle, state goes to IDLE.
  - For len == 0, done pulses on the first DRAIN cycle with no output byte.
- Output rules:
  - out_data and out_valid are registered and stable while out_valid && !out_ready.
  - in_ready is 0 in IDLE, LOAD, WARMUP and DRAIN.
- Boundaries:
  - cfg_start outside IDLE is ignored.
  - The byte counter is LEN_W bits; len = 2^LEN_W-1 completes without wrap.
- Reset mid-message: everything returns to reset values immediately, any pending output is dropped, and done is not pulsed.

Optional Feature:
- Macro KS_STUCK_DETECT_EN. When defined, adds output ks_stuck (1 bit, reset 0).
  - Set sticky if, in any cycle following an lfsr_enable, keystream equals its value before the advance, or keystream == 8'h00.
  - Cleared only by reset or cfg_start.
  - While set, in_ready is forced to 0 (the message stalls).
- When undefined: no port, no compare logic, no stall path.

Decomposition:
- Shared package lfsr_pkg holds:
  - state enum ctrl_state_t {IDLE, LOAD, WARMUP, RUN, DRAIN};
  - constant LFSR_W = 8;
  - constant LFSR_SAFE_SEED = 8'h01.
- No sub-module is required. The output register stage may be factored as lfsr_out_skid (1-entry valid/ready register) if reused.

Test Plan:
- Seed 8'hA5, WARMUP_CYCLES=0, len=2, data 8'h00, 8'h00 with out_ready=1 -> out 8'hA5 then 8'h4A; done 1 cycle after the second handshake.
- cfg_seed 8'h00, WARMUP_CYCLES=0, len=1, data 8'hFF -> lfsr_seed 8'h01, out 8'hFE.
- WARMUP_CYCLES=4 -> exactly 4 lfsr_enable cycles before in_ready first rises; no byte accepted earlier.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, no lfsr_enable; resumes without loss or duplication.
- len=0 -> one lfsr_load pulse, no out_valid, done pulse; cfg_start mid-RUN is ignored.
- Reset asserted in RUN after 1 of 3 bytes -> all outputs return to reset values asynchronously; a new cfg_start with seed 8'hA5 reproduces the first test's output.
